// File: rtl/keypad_fifo_reader.sv
// Read-side controller for the keypad FIFO: pops keycodes, drives the two-digit
// display and pairs keycodes into bytes offered over a valid/ready handshake.
module keypad_fifo_reader #(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    HOLD_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_CODE  = 4'hF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    empty,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  output logic                    read,
  output logic [DATA_WIDTH-1:0]   left_digit,
  output logic [DATA_WIDTH-1:0]   right_digit,
  output logic                    digits_valid,
  output logic                    pending,
  output logic [2*DATA_WIDTH-1:0] byte_out,
  output logic                    byte_valid,
  input  logic                    byte_ready
);

  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_reg;
  logic [15:0] hold_cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      read         <= 1'b0;
      left_digit   <= '0;
      right_digit  <= '0;
      digits_valid <= 1'b0;
      pending      <= 1'b0;
      byte_out     <= '0;
      byte_valid   <= 1'b0;
    end else begin
      // Transfer first; a low-nibble capture below can re-arm byte_valid.
      if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          // A full entry waiting on the consumer blocks further pops.
          if (!empty && !(pending && byte_valid)) begin
            state_reg <= POP;
            read      <= 1'b1;
          end
        end

        POP: begin
          read      <= 1'b0;
          state_reg <= WAIT;
        end

        WAIT: begin
          state_reg    <= HOLD;
          hold_cnt_reg <= HOLD_INIT;
          if (fifo_data == CLEAR_CODE) begin
            left_digit   <= '0;
            right_digit  <= '0;
            digits_valid <= 1'b0;
            pending      <= 1'b0;
          end else if (!pending) begin
            left_digit   <= fifo_data;
            right_digit  <= '0;
            digits_valid <= 1'b1;
            pending      <= 1'b1;
          end else begin
            right_digit <= fifo_data;
            byte_out    <= {left_digit, fifo_data};
            byte_valid  <= 1'b1;
            pending     <= 1'b0;
          end
        end

        HOLD: begin
          if (hold_cnt_reg <= 16'd1) begin
            state_reg <= IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg - 16'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_fifo_reader.sv
// Bench for keypad_fifo_reader: FIFO models feed two instances (hold 16 and 1);
// completed bytes are predicted into scoreboards and compared on each transfer.
module tb_keypad_fifo_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n;

  // Instance A: default hold time
  logic       empty_a, read_a, dv_a, pend_a, bv_a, br_a;
  logic [3:0] fifo_data_a = 4'h0;
  logic [3:0] left_a, right_a;
  logic [7:0] bo_a;

  // Instance B: hold time of one cycle
  logic       empty_b, read_b, dv_b, pend_b, bv_b, br_b;
  logic [3:0] fifo_data_b = 4'h0;
  logic [3:0] left_b, right_b;
  logic [7:0] bo_b;

  keypad_fifo_reader #(.DATA_WIDTH(4), .HOLD_CYCLES(16), .CLEAR_CODE(4'hF)) dut_a (
    .clock(clock), .reset(reset_n), .empty(empty_a), .fifo_data(fifo_data_a),
    .read(read_a), .left_digit(left_a), .right_digit(right_a),
    .digits_valid(dv_a), .pending(pend_a), .byte_out(bo_a),
    .byte_valid(bv_a), .byte_ready(br_a)
  );

  keypad_fifo_reader #(.DATA_WIDTH(4), .HOLD_CYCLES(1), .CLEAR_CODE(4'hF)) dut_b (
    .clock(clock), .reset(reset_n), .empty(empty_b), .fifo_data(fifo_data_b),
    .read(read_b), .left_digit(left_b), .right_digit(right_b),
    .digits_valid(dv_b), .pending(pend_b), .byte_out(bo_b),
    .byte_valid(bv_b), .byte_ready(br_b)
  );

  // FIFO models: registered read data, valid the cycle after read
  logic [3:0] mem_a [64];
  logic [3:0] mem_b [64];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);

  always @(posedge clock) begin
    if (read_a && (wr_a != rd_a)) begin
      fifo_data_a <= mem_a[rd_a % 64];
      rd_a        <= rd_a + 1;
    end
    if (read_b && (wr_b != rd_b)) begin
      fifo_data_b <= mem_b[rd_b % 64];
      rd_b        <= rd_b + 1;
    end
  end

  // Scoreboards and pairing models
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic       mp_a = 1'b0, mp_b = 1'b0;
  logic [3:0] mh_a = 4'h0, mh_b = 4'h0;

  int checks = 0, errors = 0;
  int cyc = 0, read_cnt_a = 0, read_cnt_b = 0, last_rd_b = 0;
  logic       prev_bv_a = 1'b0, prev_bv_b = 1'b0;
  logic [7:0] prev_bo_a = 8'h0, prev_bo_b = 8'h0;

  typedef struct {
    logic [3:0] key;
    logic [3:0] left;
    logic [3:0] right;
    logic       dv;
    logic       pend;
    logic       bv;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_raw_a(input logic [3:0] k);
    mem_a[wr_a % 64] = k;
    wr_a++;
  endtask

  task automatic push_a(input logic [3:0] k);
    push_raw_a(k);
    if (k == 4'hF) mp_a = 1'b0;
    else if (!mp_a) begin mh_a = k; mp_a = 1'b1; end
    else begin exp_a.push_back({mh_a, k}); mp_a = 1'b0; end
  endtask

  task automatic push_b(input logic [3:0] k);
    mem_b[wr_b % 64] = k;
    wr_b++;
    if (k == 4'hF) mp_b = 1'b0;
    else if (!mp_b) begin mh_b = k; mp_b = 1'b1; end
    else begin exp_b.push_back({mh_b, k}); mp_b = 1'b0; end
  endtask

  // Called once per negedge; ready seen now is what the previous posedge used.
  task automatic monitor();
    logic [7:0] e;
    cyc++;
    if (read_a) begin
      read_cnt_a++;
      chk("read_a_nonempty", {31'b0, empty_a}, 0);
    end
    if (read_b) begin
      if (read_cnt_b > 0) chk("b_read_spacing", cyc - last_rd_b, 4);
      last_rd_b = cyc;
      read_cnt_b++;
      chk("read_b_nonempty", {31'b0, empty_b}, 0);
    end
    if (prev_bv_a && br_a) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_a: got byte %h, expected none", prev_bo_a);
      end else begin
        e = exp_a.pop_front();
        chk("xfer_a", {24'b0, prev_bo_a}, {24'b0, e});
        $display("xfer a: byte %h (expected %h)", prev_bo_a, e);
      end
      chk("bv_drop_a", {31'b0, bv_a}, 0);
    end else if (reset_n && prev_bv_a && bv_a) begin
      chk("bo_stable_a", {24'b0, bo_a}, {24'b0, prev_bo_a});
    end
    if (prev_bv_b && br_b) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_b: got byte %h, expected none", prev_bo_b);
      end else begin
        e = exp_b.pop_front();
        chk("xfer_b", {24'b0, prev_bo_b}, {24'b0, e});
        $display("xfer b: byte %h (expected %h)", prev_bo_b, e);
      end
      chk("bv_drop_b", {31'b0, bv_b}, 0);
    end
    prev_bv_a = bv_a; prev_bo_a = bo_a;
    prev_bv_b = bv_b; prev_bo_b = bo_b;
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
  endtask

  task automatic wait_read_a(output int c);
    c = -1;
    for (int n = 0; n < 300; n++) begin
      step();
      if (read_a) begin
        c = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL wait_read_a: got no read within 300 cycles, expected a pulse");
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_read"},  {31'b0, read_a}, 0);
    chk({tag, "_left"},  {28'b0, left_a}, 0);
    chk({tag, "_right"}, {28'b0, right_a}, 0);
    chk({tag, "_dv"},    {31'b0, dv_a}, 0);
    chk({tag, "_pend"},  {31'b0, pend_a}, 0);
    chk({tag, "_bo"},    {24'b0, bo_a}, 0);
    chk({tag, "_bv"},    {31'b0, bv_a}, 0);
  endtask

  initial begin
    vec_t vec [6];
    int   rdc [6];
    int   c, rc;

    vec[0] = '{4'h3, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0};
    vec[1] = '{4'hA, 4'h3, 4'hA, 1'b1, 1'b0, 1'b1};
    vec[2] = '{4'h5, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0};
    vec[3] = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vec[4] = '{4'h2, 4'h2, 4'h0, 1'b1, 1'b1, 1'b0};
    vec[5] = '{4'h7, 4'h2, 4'h7, 1'b1, 1'b0, 1'b1};

    reset_n = 1'b0;
    br_a    = 1'b1;
    br_b    = 1'b1;
    repeat (3) step();
    chk_zero_a("reset");
    reset_n = 1'b1;

    // Empty FIFO: nothing moves
    rc = read_cnt_a;
    repeat (200) step();
    chk("idle_no_read", read_cnt_a - rc, 0);
    chk_zero_a("idle");

    // Pairing, clear code and display sequencing
    for (int i = 0; i < 6; i++) begin
      push_a(vec[i].key);
      wait_read_a(c);
      rdc[i] = c;
      step();
      chk($sformatf("v%0d_read_pulse", i), {31'b0, read_a}, 0);
      step();
      chk($sformatf("v%0d_left", i),  {28'b0, left_a},  {28'b0, vec[i].left});
      chk($sformatf("v%0d_right", i), {28'b0, right_a}, {28'b0, vec[i].right});
      chk($sformatf("v%0d_dv", i),    {31'b0, dv_a},    {31'b0, vec[i].dv});
      chk($sformatf("v%0d_pend", i),  {31'b0, pend_a},  {31'b0, vec[i].pend});
      chk($sformatf("v%0d_bv", i),    {31'b0, bv_a},    {31'b0, vec[i].bv});
    end
    chk("read_spacing", rdc[1] - rdc[0], 19);
    repeat (40) step();
    chk("sb_a_drained", exp_a.size(), 0);

    // Backpressure: 12 held, 3 captured, 4 left in the FIFO
    br_a = 1'b0;
    push_a(4'h1); push_a(4'h2); push_a(4'h3); push_a(4'h4);
    repeat (120) step();
    chk("bp_bv",   {31'b0, bv_a},   1);
    chk("bp_byte", {24'b0, bo_a},   32'h12);
    chk("bp_pend", {31'b0, pend_a}, 1);
    chk("bp_left", {28'b0, left_a}, 3);
    rc = read_cnt_a;
    repeat (40) step();
    chk("bp_no_read",    read_cnt_a - rc, 0);
    chk("bp_fifo_level", wr_a - rd_a, 1);
    br_a = 1'b1;
    for (int n = 0; n < 200 && exp_a.size() != 0; n++) step();
    chk("bp_sb_drained", exp_a.size(), 0);
    chk("bp_left_end",  {28'b0, left_a},  3);
    chk("bp_right_end", {28'b0, right_a}, 4);
    chk("bp_pend_end",  {31'b0, pend_a},  0);

    // Reset during WAIT abandons the popped key
    push_raw_a(4'h9);
    wait_read_a(c);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk_zero_a("rst_wait");
    mp_a = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    push_a(4'h6);
    wait_read_a(c);
    step();
    step();
    chk("post_rst_left",  {28'b0, left_a},  6);
    chk("post_rst_right", {28'b0, right_a}, 0);
    chk("post_rst_pend",  {31'b0, pend_a},  1);
    chk("post_rst_dv",    {31'b0, dv_a},    1);

    // Minimum hold time: reads every 4 cycles, four bytes in order
    for (int k = 1; k <= 8; k++) push_b(4'(k));
    for (int n = 0; n < 300 && exp_b.size() != 0; n++) step();
    repeat (5) step();
    chk("b_sb_drained", exp_b.size(), 0);
    chk("b_read_count", read_cnt_b, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_fifo_reader.md
Name: keypad_fifo_reader

Overview:
- Read-side controller for the keypad FIFO.
- Pops 4-bit keycodes from the FIFO one at a time and shows them on the two-digit display.
- Pairs consecutive keycodes into an 8-bit entry and hands each entry to a downstream consumer over a valid/ready handshake.
- Enforces a minimum display hold time between pops and treats one keycode as "clear entry".

Parameters:
- DATA_WIDTH, 4, keycode width; fixed at 4, no other value supported.
- HOLD_CYCLES, 16, clock cycles each captured key stays displayed before the next pop; legal range 1 to 65535.
- CLEAR_CODE, 4'hF, keycode that discards a partial entry instead of being stored.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- empty  input  1  FIFO empty flag.
- fifo_data  input  4  FIFO read data; valid in the cycle after read is high.
- read  output  1  FIFO pop strobe; exactly one cycle per pop.
- left_digit  output  4  display nibble, high digit of the entry.
- right_digit  output  4  display nibble, low digit of the entry.
- digits_valid  output  1  display enable; 1 when either digit holds a captured key.
- pending  output  1  high nibble captured, low nibble not yet received.
- byte_out  output  8  completed entry {high, low}.
- byte_valid  output  1  byte_out is valid; held until accepted.
- byte_ready  input  1  consumer accepts byte_out.

Behaviour:
- Reset (reset low, asynchronous):
  - State returns to IDLE; hold counter clears.
  - All outputs go to 0: read, left_digit, right_digit, digits_valid, pending, byte_out, byte_valid.
  - A pop in flight is abandoned; its data is never captured.
- All outputs are registered.
- States: IDLE, POP, WAIT, HOLD.
- IDLE:
  - Goes to POP when empty == 0 and not (pending && byte_valid).
  - Otherwise stays in IDLE.
- POP: read = 1 for this single cycle; go to WAIT.
- WAIT:
  - fifo_data is valid in this cycle and is sampled at the closing edge.
  - Go to HOLD and load the counter with HOLD_CYCLES.
- Capture rules, applied at the WAIT closing edge:
  - Code == CLEAR_CODE: left_digit = 0, right_digit = 0, digits_valid = 0, pending = 0. byte_out and byte_valid are untouched.
  - Other code with pending == 0: left_digit = code, right_digit = 0, digits_valid = 1, pending = 1.
  - Other code with pending == 1: right_digit = code, byte_out = {left_digit, code}, byte_valid = 1, pending = 0.
- HOLD:
  - Counter decrements each cycle.
  - When it reaches 1, go to IDLE, so HOLD lasts exactly HOLD_CYCLES cycles.
- Pop timing:
  - Latency: empty falls in cycle n while IDLE → read high in cycle n+1 → digits update visible in cycle n+3.
  - Minimum read-to-read spacing is HOLD_CYCLES+3 cycles.
- Handshake:
  - Transfer happens on any rising edge where byte_valid && byte_ready; byte_valid falls the next cycle.
  - byte_out is stable while byte_valid is high.
  - byte_ready while byte_valid is low is ignored.
  - Transfer may coincide with any state, including a WAIT capture of a high nibble.
- Backpressure:
  - With pending = 1 and byte_valid = 1, IDLE does not pop, so byte_out is never overwritten.
  - The FIFO absorbs keys meanwhile.
- Boundaries:
  - empty rising during WAIT or HOLD has no effect.
  - read is never asserted while empty == 1 was sampled in IDLE.
  - A clear code while byte_valid = 1 still pops and clears the display; the pending byte remains offered.

Test Plan:
- Push 4'h3 then 4'hA, byte_ready = 1 → two read pulses spaced 19 cycles; display 3/0 then 3/A; byte_out = 8'h3A, byte_valid high for 1 cycle.
- Push 4'h5, 4'hF, 4'h2, 4'h7 → after F: digits 0/0, digits_valid = 0, pending = 0; final byte_out = 8'h27, no byte ever formed from 5.
- byte_ready = 0; push 1, 2, 3, 4 → byte_out = 8'h12 held; 3 is captured (pending = 1), then no read pulse while 4 sits in FIFO; raise byte_ready → 8'h12 accepted, 4 popped, byte_out = 8'h34.
- FIFO held empty for 200 cycles → read never asserted; outputs remain at reset values.
- Assert reset in the WAIT cycle after popping 4'h9 → all outputs 0 immediately; after release, the next pop (4'h6) shows left_digit = 6, pending = 1.
- HOLD_CYCLES = 1, FIFO preloaded with 8 keys → read pulses every 4 cycles; 4 bytes emitted in order with byte_ready tied high.
